// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a bank of WIDTH JK flip-flops via J/K/CLR and checks Q.
// Optional retry on check mismatch is enabled by defining JK_BANK_RETRY_EN.
module jk_bank_driver #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             CLR_N,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             pre_o,
    output logic             clr_o,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_exp_c;
    logic             mismatch_c;
`ifdef JK_BANK_RETRY_EN
    logic             retried;
`endif

    // The bank has no preset path in use.
    assign pre_o = 1'b0;

    // Target value for a newly accepted request, from the op and current Q.
    always_comb begin
        acc_exp_c = '0;
        case (req_op)
            OP_LOAD:  acc_exp_c = req_data;
            OP_INC:   acc_exp_c = q_fb + WIDTH'(1);
            OP_DEC:   acc_exp_c = q_fb - WIDTH'(1);
            OP_CLEAR: acc_exp_c = '0;
            default:  acc_exp_c = '0;
        endcase
    end

    // Final-check comparison of bank Q against the latched target.
    always_comb begin
        mismatch_c = (q_fb != exp_q);
    end

    // Control FSM with registered outputs; J/K are only non-zero in DRIVE.
    always_ff @(posedge clk) begin
        if (!CLR_N) begin
            state     <= S_IDLE;
            exp_q     <= '0;
            cnt       <= '0;
            j_o       <= '0;
            k_o       <= '0;
            clr_o     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
`ifdef JK_BANK_RETRY_EN
            retried   <= 1'b0;
`endif
        end else begin
            j_o   <= '0;
            k_o   <= '0;
            clr_o <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid && req_ready) begin
                        exp_q     <= acc_exp_c;
                        state     <= S_DRIVE;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
`ifdef JK_BANK_RETRY_EN
                        retried   <= 1'b0;
`endif
                        if (req_op == OP_CLEAR) begin
                            clr_o <= 1'b1;
                        end else begin
                            // Set bits that must rise, reset bits that must fall.
                            j_o <= ~q_fb & acc_exp_c;
                            k_o <= q_fb & ~acc_exp_c;
                        end
                    end
                end
                S_DRIVE: begin
                    state <= S_SETTLE;
                    cnt   <= CW'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CHECK: begin
`ifdef JK_BANK_RETRY_EN
                    if (mismatch_c && !retried) begin
                        // One more attempt toward the same target from the current Q.
                        retried <= 1'b1;
                        state   <= S_DRIVE;
                        j_o     <= ~q_fb & exp_q;
                        k_o     <= q_fb & ~exp_q;
                    end else begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                        err       <= mismatch_c;
                    end
`else
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    done      <= 1'b1;
                    err       <= mismatch_c;
`endif
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Testbench for jk_bank_driver: behavioural JK bank plus transaction-timeline model.
module tb_jk_bank_driver;

    localparam int W   = 4;
    localparam int ST  = 2;
    localparam int MOD = 1 << W;
`ifdef JK_BANK_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [W-1:0] req_data = '0;
    logic [W-1:0] q_fb;
    logic [W-1:0] j_o, k_o;
    logic         pre_o, clr_o, busy, done, err;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // Behavioural bank: internal state, optional stuck-at-0 on outputs, bench-side forcing.
    logic [W-1:0] bank = '0;
    logic [W-1:0] stk = '0;
    logic         frc_en = 1'b0;
    logic [W-1:0] frc_val = '0;

    assign q_fb = bank & ~stk;

    jk_bank_driver #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk(clk), .CLR_N(clr_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .q_fb(q_fb), .j_o(j_o), .k_o(k_o),
        .pre_o(pre_o), .clr_o(clr_o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                               input logic [W-1:0] k, input logic clr, input logic pre);
        logic [W-1:0] n;
        n = q;
        if (clr) return '0;
        if (pre) return '1;
        for (int i = 0; i < W; i++) begin
            if (j[i] && k[i])      n[i] = ~q[i];
            else if (j[i])         n[i] = 1'b1;
            else if (k[i])         n[i] = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (frc_en) bank <= frc_val;
        else        bank <= bank_next(bank, j_o, k_o, clr_o, pre_o);
    end

    // Model: t counts cycles since accept (0 = idle); expected outputs for the next cycle.
    typedef struct packed {
        logic         ready;
        logic [7:0]   t;
        logic [W-1:0] exp_v;
        logic         retried;
        logic         busy;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic         eclr;
        logic         edone;
        logic         eerr;
    } mdl_t;

    mdl_t m = '0;

    function automatic logic [W-1:0] target(input logic [1:0] op, input logic [W-1:0] d,
                                            input logic [W-1:0] q);
        case (op)
            2'b00:   return d;
            2'b01:   return W'((int'(q) + 1) % MOD);
            2'b10:   return W'((int'(q) + MOD - 1) % MOD);
            default: return '0;
        endcase
    endfunction

    function automatic mdl_t step(input mdl_t c, input logic rn, input logic v, input logic [1:0] op,
                                  input logic [W-1:0] d, input logic [W-1:0] q);
        mdl_t n;
        n = c;
        n.ej = '0; n.ek = '0; n.eclr = 1'b0; n.edone = 1'b0; n.eerr = 1'b0;
        if (!rn) begin
            n.ready = 1'b0; n.t = 8'd0; n.exp_v = '0; n.busy = 1'b0; n.retried = 1'b0;
        end else if (c.t == 8'd0) begin
            if (v && c.ready) begin
                n.exp_v = target(op, d, q);
                n.t = 8'd1; n.ready = 1'b0; n.busy = 1'b1; n.retried = 1'b0;
                if (op == 2'b11) n.eclr = 1'b1;
                else begin
                    n.ej = ~q & n.exp_v;
                    n.ek = q & ~n.exp_v;
                end
            end else begin
                n.ready = 1'b1; n.busy = 1'b0;
            end
        end else if (c.t < 8'(ST + 2)) begin
            n.t = c.t + 8'd1;
        end else begin
            if (RETRY && (q != c.exp_v) && !c.retried) begin
                n.retried = 1'b1; n.t = 8'd1;
                n.ej = ~q & c.exp_v;
                n.ek = q & ~c.exp_v;
            end else begin
                n.t = 8'd0; n.busy = 1'b0; n.ready = 1'b1;
                n.edone = 1'b1; n.eerr = (q != c.exp_v);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m, clr_n, req_valid, req_op, req_data, q_fb);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle: move to the next negedge and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(m.ready));
            chk("busy",      32'(busy),      32'(m.busy));
            chk("done",      32'(done),      32'(m.edone));
            chk("err",       32'(err),       32'(m.eerr));
            chk("j_o",       32'(j_o),       32'(m.ej));
            chk("k_o",       32'(k_o),       32'(m.ek));
            chk("clr_o",     32'(clr_o),     32'(m.eclr));
            chk("pre_o",     32'(pre_o),     32'd0);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(m.t == 8'd0 && m.ready) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic force_bank(input logic [W-1:0] v);
        frc_val = v;
        frc_en = 1'b1;
        tick();
        frc_en = 1'b0;
    endtask

    // Present a request for one edge; returns in the cycle after that edge.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d);
        req_valid = 1'b1;
        req_op = op;
        req_data = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int dcnt;
        int ecnt;
        @(posedge clk);
        chk_on = 1'b1;
        tick();
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        chk("busy_in_reset", 32'(busy), 32'd0);
        clr_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // LOAD 4'hA from 0
        force_bank(4'h0);
        wait_idle();
        send(2'b00, 4'hA);
        chk("load_j", 32'(j_o), 32'hA);
        chk("load_k", 32'(k_o), 32'h0);
        cyc(4);
        chk("load_done", 32'(done), 32'd1);
        chk("load_err", 32'(err), 32'd0);
        chk("load_q", 32'(q_fb), 32'hA);

        // INC wraps F -> 0
        force_bank(4'hF);
        wait_idle();
        send(2'b01, 4'h3);
        chk("inc_j", 32'(j_o), 32'h0);
        chk("inc_k", 32'(k_o), 32'hF);
        cyc(4);
        chk("inc_done", 32'(done), 32'd1);
        chk("inc_err", 32'(err), 32'd0);
        chk("inc_q", 32'(q_fb), 32'h0);

        // DEC wraps 0 -> F
        wait_idle();
        send(2'b10, 4'h0);
        chk("dec_j", 32'(j_o), 32'hF);
        chk("dec_k", 32'(k_o), 32'h0);
        cyc(4);
        chk("dec_done", 32'(done), 32'd1);
        chk("dec_q", 32'(q_fb), 32'hF);

        // CLEAR from 5
        force_bank(4'h5);
        wait_idle();
        send(2'b11, 4'h9);
        chk("clear_clr", 32'(clr_o), 32'd1);
        chk("clear_jk", 32'({j_o, k_o}), 32'h0);
        tick();
        chk("clear_clr_once", 32'(clr_o), 32'd0);
        cyc(3);
        chk("clear_done", 32'(done), 32'd1);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_q", 32'(q_fb), 32'h0);

        // Bit 0 stuck at 0, LOAD 1
        stk = 4'h1;
        force_bank(4'h0);
        wait_idle();
        send(2'b00, 4'h1);
        chk("stuck_j", 32'(j_o), 32'h1);
        cyc(4);
        if (RETRY) begin
            chk("stuck_retry_j", 32'(j_o), 32'h1);
            chk("stuck_retry_nodone", 32'(done), 32'd0);
            cyc(4);
        end
        chk("stuck_done", 32'(done), 32'd1);
        chk("stuck_err", 32'(err), 32'd1);
        stk = '0;

        // req_valid held high: one accept per SETTLE+3 cycles
        wait_idle();
        dcnt = 0;
        ecnt = 0;
        req_valid = 1'b1;
        req_op = 2'($urandom_range(0, 3));
        req_data = W'($urandom);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) dcnt++;
            if (err) ecnt++;
            req_op = 2'($urandom_range(0, 3));
            req_data = W'($urandom);
        end
        req_valid = 1'b0;
        chk("hold_done_count", 32'(dcnt), 32'd10);
        chk("hold_err_count", 32'(ecnt), 32'd0);

        // Reset during SETTLE drops the request
        wait_idle();
        send(2'b00, 4'h6);
        tick();
        clr_n = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drive", 32'({j_o, k_o, clr_o}), 32'd0);
        clr_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("rst_no_done", 32'(dcnt), 32'd0);
        wait_idle();
        send(2'b00, 4'h3);
        cyc(4);
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_q", 32'(q_fb), 32'h3);

        // Randomized traffic with occasional resets and stuck bits
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op = 2'($urandom_range(0, 3));
            req_data = W'($urandom);
            clr_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 79) == 0) stk = W'($urandom_range(0, 3));
            tick();
        end
        req_valid = 1'b0;
        clr_n = 1'b1;
        stk = '0;
        wait_idle();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Sequential controller that drives a bank of WIDTH JK master-slave flip-flops through their J/K/PRE/CLR inputs and reads the bank's Q outputs back for verification. It accepts load, increment, decrement and clear requests over a valid/ready handshake. For each request it computes per-bit J/K excitation from the current Q, waits for the bank to settle, then checks the result. It sits between register-level control logic and the gate-level flip-flop bank, which has no excitation logic of its own.

## Interface
- WIDTH, 4: number of flip-flops in the driven bank.
- SETTLE, 2: idle cycles between excitation and check; ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- CLR_N  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- req_data  in  WIDTH  target value for LOAD; ignored otherwise.
- q_fb  in  WIDTH  Q outputs of the bank.
- j_o, k_o  out  WIDTH  per-bit J and K to the bank.
- pre_o, clr_o  out  1  bank preset/clear, active-high; pre_o is tied 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means q_fb ≠ expected at the final check.

## Operation
- States: IDLE → DRIVE → SETTLE (SETTLE cycles) → CHECK → IDLE.
- Accept:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - On acceptance, latch `exp`: LOAD = req_data; INC = q_fb+1; DEC = q_fb−1; CLEAR = 0.
  - INC and DEC are modulo 2^WIDTH: all-ones+1 = 0 and 0−1 = all-ones.
- DRIVE (one cycle), per bit i, computed from registered q_fb:
  - 0→0: J=0, K=0.
  - 0→1: J=1, K=0.
  - 1→0: J=0, K=1.
  - 1→1: J=0, K=0.
  - For CLEAR, j_o = k_o = 0 and clr_o = 1 instead.
- SETTLE: j_o, k_o and clr_o are all 0. A down-counter runs from SETTLE−1 to 0.
- CHECK:
  - Compare q_fb with exp.
  - Next cycle: IDLE, done=1, err=(mismatch), req_ready=1.
- Outputs are registered. j_o, k_o and clr_o are non-zero only in the DRIVE cycle.
- While busy, req_valid is ignored; nothing is queued.
- Reset: CLR_N low at an edge forces IDLE from any state. The in-flight request is dropped with no done.

## Timing
- Reset values:
  - req_ready=1 after the first edge with CLR_N high; 0 while CLR_N is low.
  - j_o=0, k_o=0, pre_o=0, clr_o=0, busy=0, done=0, err=0; exp=0.
- Request accepted at edge N:
  - DRIVE outputs are visible in cycle N+1.
  - SETTLE occupies N+2 … N+1+SETTLE.
  - CHECK is N+2+SETTLE.
  - done/err are high in cycle N+3+SETTLE, with req_ready=1 in the same cycle.
- Back-to-back: a request presented in the done cycle is accepted at that edge. Throughput is one request per SETTLE+3 cycles.
- Reset mid-DRIVE: j_o, k_o and clr_o are 0 in the cycle after the reset edge.

## Configuration
- JK_BANK_RETRY_EN defined:
  - On a CHECK mismatch, return to DRIVE once, recomputing J/K from the current q_fb toward the same exp.
  - A second mismatch ends with done=1, err=1.
  - Retry adds SETTLE+2 cycles of latency.
- Undefined: the first CHECK mismatch ends the request with done=1, err=1; no retry state or counter exists.

## Test plan
- Reset then LOAD 4'hA with bank at 0 (behavioural JK model): DRIVE cycle shows j_o=4'hA, k_o=0; done at N+5 (SETTLE=2), err=0, q_fb=4'hA.
- Bank at 4'hF, INC: j_o=0, k_o=4'hF; wraps to 0, err=0. Then DEC from 0: j_o=4'hF, k_o=0; result 4'hF.
- CLEAR from 4'h5: clr_o=1 for exactly one cycle, j_o=k_o=0; q_fb=0, err=0.
- Model forces bit 0 stuck-at-0, LOAD 4'h1:
  - Macro undefined: done with err=1 at N+5.
  - JK_BANK_RETRY_EN: second DRIVE at N+5, done with err=1 at N+9.
- Hold req_valid high continuously: one accept per 5 cycles; no accept while busy; req_data changes during busy have no effect.
- Assert CLR_N low during SETTLE: next cycle busy=0, all drive outputs 0, no done pulse. The next request completes normally.
